cordic_post: RTL and testbench

//  Output stage of the CORDIC pipeline, the inverse of the input-range stage. Takes raw x/y/z
//  (Q16.8, 24-bit) from the last CORDIC iteration and removes the CORDIC gain. Undoes the quadrant

---
 rtl/cordic_pkg.sv | 61 ++++++
 rtl/cordic_post_fifo.sv | 61 ++++++
 rtl/cordic_post.sv | 156 +++++++++++++++
 tb/tb_cordic_post.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared Q16.8 widths, gain/quadrant constants and result types for the CORDIC pipeline.
// Latency: n/a (declarations and a combinational saturation helper only).
// Backpressure: n/a.
`timescale 1ns/1ps
package cordic_pkg;

   // Fixed-point formats: Q16.8 inside the pipeline, Q8.8 / integer degrees at the output
   localparam int W_IN   = 24;
   localparam int W_OUT  = 16;
   localparam int FRAC   = 8;
   // Internal width: headroom for 3*90 degrees added to a full-scale Q16.8 angle, plus negation
   localparam int W_ANG  = 26;
   localparam int W_SEL  = 4;

   // 1/K gain compensation, unsigned Q0.16 (0.60725)
   localparam int KINV      = 39797;
   // 90 degrees in Q16.8
   localparam int QUAD_STEP = 23040;

   // in_select bit choosing vectoring (1) or rotation (0)
   localparam int SEL_VEC = 3;

   // Quadrant folding applied by the entry stage
   localparam logic [1:0] QUAD_0   = 2'd0;
   localparam logic [1:0] QUAD_90  = 2'd1;
   localparam logic [1:0] QUAD_180 = 2'd2;
   localparam logic [1:0] QUAD_270 = 2'd3;

   // Saturation limits of a signed 16-bit result, held at internal width
   localparam logic signed [W_ANG-1:0] SAT_HI = W_ANG'(32767);
   localparam logic signed [W_ANG-1:0] SAT_LO = -W_ANG'(32768);

   // One finished result as it sits in the output FIFO (38 bits)
   typedef struct packed {
      logic [W_OUT-1:0] res0;
      logic [W_OUT-1:0] res1;
      logic [1:0]       ovf;
      logic [W_SEL-1:0] sel;
   } res_t;

   typedef struct packed {
      logic             ovf;
      logic [W_OUT-1:0] val;
   } sat_t;

   // Clamp an internal-width signed value into signed 16 bits, flagging when clamped
   function automatic sat_t sat16(input logic signed [W_ANG-1:0] v);
      sat_t r;
      r.ovf = 1'b0;
      r.val = v[W_OUT-1:0];
      if (v > SAT_HI) begin
         r.ovf = 1'b1;
         r.val = 16'h7FFF;
      end else if (v < SAT_LO) begin
         r.ovf = 1'b1;
         r.val = 16'h8000;
      end
      return r;
   endfunction

endpackage

// File: rtl/cordic_post_fifo.sv
// cordic_post_fifo: synchronous FIFO with occupancy count, head presented combinationally.
// Latency: 1 cycle push-to-head when empty; pop takes effect on the clock edge.
// Backpressure: push while full is ignored (the upstream credit scheme never does it); pop when empty ignored.
`timescale 1ns/1ps
module cordic_post_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 38
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_vld_i,
   input  logic [W-1:0]                 push_dat_i,
   input  logic                         pop_rdy_i,
   output logic                         pop_vld_o,
   output logic [W-1:0]                 pop_dat_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   // Handshake qualification and next pointer/count values
   always_comb begin
      do_pop   = pop_rdy_i && (cnt_q != '0);
      do_push  = push_vld_i && ((cnt_q != DEPTH_C) || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + LW'(1);
         2'b01:   cnt_d = cnt_q - LW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage and pointers; reset clears the array so the head reads zero while empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pop_vld_o = (cnt_q != '0);
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign level_o   = cnt_q;

endmodule

// File: rtl/cordic_post.sv
// cordic_post: removes CORDIC gain, undoes entry quadrant folding, rounds/saturates to 16-bit results.
// Latency: out_valid rises 2 cycles after accept (S1 gain+unfold, S2 round+saturate, FIFO push).
// Backpressure: credit based; in_ready drops once FIFO plus in-flight stages would fill the FIFO, never drops data.
`timescale 1ns/1ps
module cordic_post #(
   parameter int FIFO_DEPTH = 4,
   parameter int KINV       = cordic_pkg::KINV,
   parameter int QUAD_STEP  = cordic_pkg::QUAD_STEP
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [cordic_pkg::W_IN-1:0]         in_x,
   input  logic [cordic_pkg::W_IN-1:0]         in_y,
   input  logic [cordic_pkg::W_IN-1:0]         in_z,
   input  logic [cordic_pkg::W_SEL-1:0]        in_select,
   input  logic [1:0]                          in_quad,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [cordic_pkg::W_OUT-1:0]        out_res0,
   output logic [cordic_pkg::W_OUT-1:0]        out_res1,
   output logic [1:0]                          out_ovf,
   output logic [cordic_pkg::W_SEL-1:0]        out_select,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);
   import cordic_pkg::*;

   localparam int LW     = $clog2(FIFO_DEPTH+1);
   localparam int W_PROD = W_IN + 17;   // signed 24-bit value times unsigned 16-bit gain

   localparam logic [LW:0]                DEPTH_C  = (LW+1)'(FIFO_DEPTH);
   localparam logic signed [W_PROD-1:0]   KINV_E   = W_PROD'(KINV);
   localparam logic signed [W_PROD-1:0]   GAIN_RND = W_PROD'(32768);
   localparam logic signed [W_ANG-1:0]    QS_90    = W_ANG'(QUAD_STEP);
   localparam logic signed [W_ANG-1:0]    QS_180   = W_ANG'(2*QUAD_STEP);
   localparam logic signed [W_ANG-1:0]    QS_270   = W_ANG'(3*QUAD_STEP);
   localparam logic signed [W_ANG-1:0]    ANG_RND  = W_ANG'(128);

   // ---------------- credit accounting ----------------
   logic          s1_vld_q, s2_vld_q;
   logic [LW-1:0] fifo_level;
   logic [LW:0]   used;
   logic          accept;

   // Every accepted result owns a FIFO slot from accept until it is popped
   always_comb begin
      used = {1'b0, fifo_level}
           + {{LW{1'b0}}, s1_vld_q}
           + {{LW{1'b0}}, s2_vld_q};
   end

   assign in_ready = (used < DEPTH_C);
   assign accept   = in_valid && in_ready;

   // ---------------- S1: gain removal and quadrant unfold ----------------
   logic signed [W_PROD-1:0] x_e, y_e;
   logic signed [W_ANG-1:0]  c, s, neg_c, neg_s, z_e, qoff;
   logic signed [W_ANG-1:0]  s1_a_d, s1_b_d, s1_a_q, s1_b_q;
   logic                     s1_vec_q;
   logic [W_SEL-1:0]         s1_sel_q;

   // Scale by 1/K with round-half-up, then place the result back into its original quadrant
   always_comb begin
      x_e   = {{(W_PROD-W_IN){in_x[W_IN-1]}}, in_x};
      y_e   = {{(W_PROD-W_IN){in_y[W_IN-1]}}, in_y};
      c     = W_ANG'((x_e * KINV_E + GAIN_RND) >>> 16);
      s     = W_ANG'((y_e * KINV_E + GAIN_RND) >>> 16);
      neg_c = -c;
      neg_s = -s;
      z_e   = {{(W_ANG-W_IN){in_z[W_IN-1]}}, in_z};
      case (in_quad)
         QUAD_90:  qoff = QS_90;
         QUAD_180: qoff = QS_180;
         QUAD_270: qoff = QS_270;
         default:  qoff = '0;
      endcase
      s1_a_d = c;
      s1_b_d = s;
      if (in_select[SEL_VEC]) begin
         // Vectoring: magnitude is quadrant-invariant, the angle gets the folded quadrant added back
         s1_a_d = c;
         s1_b_d = z_e + qoff;
      end else begin
         case (in_quad)
            QUAD_90:  begin s1_a_d = neg_s; s1_b_d = c;     end
            QUAD_180: begin s1_a_d = neg_c; s1_b_d = neg_s; end
            QUAD_270: begin s1_a_d = s;     s1_b_d = neg_c; end
            default:  begin s1_a_d = c;     s1_b_d = s;     end
         endcase
      end
   end

   // ---------------- S2: round and saturate ----------------
   logic signed [W_ANG-1:0] ang_int;
   sat_t                    sat_a, sat_b;
   res_t                    s2_res_d, s2_res_q;

   // Angle drops to integer degrees (round half up); every value then clamps to signed 16
   always_comb begin
      ang_int       = (s1_b_q + ANG_RND) >>> FRAC;
      sat_a         = sat16(s1_a_q);
      sat_b         = sat16(s1_vec_q ? ang_int : s1_b_q);
      s2_res_d.res0 = sat_a.val;
      s2_res_d.res1 = sat_b.val;
      s2_res_d.ovf  = {sat_b.ovf, sat_a.ovf};
      s2_res_d.sel  = s1_sel_q;
   end

   // Pipeline registers; stages never stall because credits reserve the FIFO slot up front
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_vec_q <= 1'b0;
         s1_sel_q <= '0;
         s2_vld_q <= 1'b0;
         s2_res_q <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_vec_q <= in_select[SEL_VEC];
            s1_sel_q <= in_select;
         end
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) s2_res_q <= s2_res_d;
      end
   end

   // ---------------- output buffer ----------------
   res_t head;

   cordic_post_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(res_t))
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_vld_i (s2_vld_q),
      .push_dat_i (s2_res_q),
      .pop_rdy_i  (out_ready),
      .pop_vld_o  (out_valid),
      .pop_dat_o  (head),
      .level_o    (fifo_level)
   );

   assign out_res0   = head.res0;
   assign out_res1   = head.res1;
   assign out_ovf    = head.ovf;
   assign out_select = head.sel;
   assign level      = fifo_level;

endmodule

// File: tb/tb_cordic_post.sv
// tb_cordic_post: scoreboard bench for cordic_post, expected results queued at accept, compared at pop.
// Latency: n/a.
// Backpressure: exercises full-FIFO stall, streaming push/pop and random out_ready.
`timescale 1ns/1ps
module tb_cordic_post;
   import cordic_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready;
   logic [23:0] in_x, in_y, in_z;
   logic [3:0]  in_select;
   logic [1:0]  in_quad;
   logic        out_valid, out_ready;
   logic [15:0] out_res0, out_res1;
   logic [1:0]  out_ovf;
   logic [3:0]  out_select;
   logic [2:0]  level;

   always #5 clk = ~clk;

   cordic_post #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .in_select(in_select), .in_quad(in_quad),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res0(out_res0), .out_res1(out_res1),
      .out_ovf(out_ovf), .out_select(out_select),
      .level(level)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t sb[$];
   logic rnd_rdy = 1'b0;
   logic held = 1'b0;
   res_t held_v, cur, exp_v;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic res_t mk(input logic [15:0] r0, input logic [15:0] r1,
                               input logic [1:0] o, input logic [3:0] s);
      res_t r;
      r.res0 = r0; r.res1 = r1; r.ovf = o; r.sel = s;
      return r;
   endfunction

   function automatic logic [16:0] sat_m(input longint v);
      if (v > 32767)  return {1'b1, 16'h7FFF};
      if (v < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(v)};
   endfunction

   // Reference model in 64-bit integer arithmetic
   function automatic res_t model(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z,
                                  input logic [3:0] sel, input logic [1:0] q);
      logic signed [23:0] sx, sy, sz;
      longint c, s, a, b;
      logic [16:0] ra, rb;
      res_t r;
      sx = x; sy = y; sz = z;
      c = (longint'(sx) * 39797 + 32768) >>> 16;
      s = (longint'(sy) * 39797 + 32768) >>> 16;
      if (sel[3]) begin
         a = c;
         b = (longint'(sz) + longint'(q) * 23040 + 128) >>> 8;
      end else begin
         case (q)
            2'd0: begin a = c;  b = s;  end
            2'd1: begin a = -s; b = c;  end
            2'd2: begin a = -c; b = -s; end
            default: begin a = s; b = -c; end
         endcase
      end
      ra = sat_m(a);
      rb = sat_m(b);
      r.res0 = ra[15:0];
      r.res1 = rb[15:0];
      r.ovf  = {rb[16], ra[16]};
      r.sel  = sel;
      return r;
   endfunction

   // Offer one input (called at posedge+1), wait for acceptance, queue its expected result
   task automatic drive_one(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z,
                            input logic [3:0] sel, input logic [1:0] q, input res_t exp);
      int waitc;
      waitc = 0;
      in_valid = 1'b1; in_x = x; in_y = y; in_z = z; in_select = sel; in_quad = q;
      @(negedge clk);
      while (!in_ready && waitc < 200) begin
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         check_eq("accept_timeout", 64'(in_ready), 64'(1));
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         sb.push_back(exp);
         #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((sb.size() != 0 || level != 3'd0) && c < 400) begin
         @(posedge clk); #1;
         c++;
      end
      check_eq("drain", 64'(sb.size()), 64'(0));
   endtask

   // Output monitor: compares every popped head against the scoreboard and checks hold-stability
   always @(negedge clk) begin
      cur = {out_res0, out_res1, out_ovf, out_select};
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held && out_valid) check_eq("hold", 64'(cur), 64'(held_v));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("sb_size", 64'(sb.size()), 64'(1));
            end else begin
               exp_v = sb.pop_front();
               check_eq("out", 64'(cur), 64'(exp_v));
            end
         end
         held   = out_valid && !out_ready;
         held_v = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [23:0] rx, ry, rz;
      logic [3:0]  rs;
      logic [1:0]  rq;
      in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_select = '0; in_quad = '0;
      out_ready = 1'b1;

      // Reset state
      #12;
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_level", 64'(level), 64'(0));
      check_eq("rst_data", 64'({out_res0, out_res1, out_ovf, out_select}), 64'(0));
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Rotation quad0 with latency measurement
      in_valid = 1'b1; in_x = 24'h00016D; in_y = 24'h0000D3; in_z = '0; in_select = 4'h1; in_quad = 2'd0;
      @(negedge clk);
      check_eq("idle_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      sb.push_back(mk(16'h00DE, 16'h0080, 2'b00, 4'h1));
      #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("latency", 64'(cyc), 64'(2));
      wait_drain();

      // Quadrant unfold, vectoring, rounding and saturation corners, back to back
      drive_one(24'h00016D, 24'h0000D3, 24'h0, 4'h1, 2'd1, mk(16'hFF80, 16'h00DE, 2'b00, 4'h1));
      drive_one(24'h00016D, 24'h0000D3, 24'h0, 4'h1, 2'd2, mk(16'hFF22, 16'hFF80, 2'b00, 4'h1));
      drive_one(24'h00016D, 24'h0000D3, 24'h0, 4'h1, 2'd3, mk(16'h0080, 16'hFF22, 2'b00, 4'h1));
      drive_one(24'h00016D, 24'h000011, 24'h001E00, 4'h8, 2'd1, mk(16'h00DE, 16'h0078, 2'b00, 4'h8));
      drive_one(24'h00016D, 24'h000011, 24'h001E80, 4'h9, 2'd0, mk(16'h00DE, 16'h001F, 2'b00, 4'h9));
      drive_one(24'h7FFFFF, 24'h800000, 24'h0, 4'h2, 2'd0, mk(16'h7FFF, 16'h8000, 2'b11, 4'h2));
      drive_one(24'h800000, 24'h000000, 24'h0, 4'h3, 2'd2, mk(16'h7FFF, 16'h0000, 2'b01, 4'h3));
      drive_one(24'h00016D, 24'h0, 24'hFFFF80, 4'h8, 2'd0, mk(16'h00DE, 16'h0000, 2'b00, 4'h8));
      drive_one(24'h00016D, 24'h0, 24'hFFFF7F, 4'h8, 2'd0, mk(16'h00DE, 16'hFFFF, 2'b00, 4'h8));
      drive_one(24'h00016D, 24'h0, 24'h7FFFFF, 4'hA, 2'd3, mk(16'h00DE, 16'h7FFF, 2'b10, 4'hA));
      idle();
      wait_drain();

      // Backpressure: exactly four accepted while the consumer stalls
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         drive_one(24'(100 * (i + 1)), 24'(50 * i), 24'h0, 4'(i), 2'(i),
                   model(24'(100 * (i + 1)), 24'(50 * i), 24'h0, 4'(i), 2'(i)));
      in_valid = 1'b1; in_x = 24'd500; in_y = 24'd200; in_z = '0; in_select = 4'h4; in_quad = 2'd0;
      @(negedge clk);
      check_eq("bp_in_ready_low", 64'(in_ready), 64'(0));
      repeat (4) @(posedge clk);
      #1;
      check_eq("bp_level_full", 64'(level), 64'(4));
      check_eq("bp_still_blocked", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      drive_one(24'd500, 24'd200, 24'h0, 4'h4, 2'd0, model(24'd500, 24'd200, 24'h0, 4'h4, 2'd0));
      drive_one(24'd600, 24'd250, 24'h0, 4'h5, 2'd1, model(24'd600, 24'd250, 24'h0, 4'h5, 2'd1));
      idle();
      wait_drain();

      // Streaming: one push and one pop every cycle keeps the level constant
      for (int i = 0; i < 8; i++) begin
         drive_one(24'(37 * i + 5), 24'(11 * i), 24'h0, 4'h6, 2'(i),
                   model(24'(37 * i + 5), 24'(11 * i), 24'h0, 4'h6, 2'(i)));
         if (i >= 3) check_eq("stream_level", 64'(level), 64'(1));
      end
      idle();
      wait_drain();

      // Reset with FIFO partly full and both stages occupied
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         drive_one(24'(300 + i), 24'(20 * i), 24'h0, 4'h7, 2'(i),
                   model(24'(300 + i), 24'(20 * i), 24'h0, 4'h7, 2'(i)));
      idle();
      check_eq("prerst_level", 64'(level), 64'(2));
      check_eq("prerst_in_ready", 64'(in_ready), 64'(0));
      #1 rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
      check_eq("midrst_level", 64'(level), 64'(0));
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("postrst_in_ready", 64'(in_ready), 64'(1));
      check_eq("postrst_level", 64'(level), 64'(0));
      out_ready = 1'b1;
      drive_one(24'h000123, 24'h000045, 24'h0, 4'hB, 2'd2, model(24'h000123, 24'h000045, 24'h0, 4'hB, 2'd2));
      idle();
      wait_drain();

      // Random traffic with random consumer stalls
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rx = 24'($urandom);
         ry = 24'($urandom);
         rz = 24'($urandom);
         if ($urandom_range(0, 1) == 1) rx = {{8{rx[15]}}, rx[15:0]};
         if ($urandom_range(0, 1) == 1) ry = {{8{ry[15]}}, ry[15:0]};
         if ($urandom_range(0, 3) != 0) rz = {{7{rz[16]}}, rz[16:0]};
         rs = 4'($urandom);
         rq = 2'($urandom);
         drive_one(rx, ry, rz, rs, rq, model(rx, ry, rz, rs, rq));
      end
      idle();
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
